// File: rtl/mipi_sc_line_writer.sv
// mipi_sc_line_writer
// Write side of the CLK_tx line FIFO. Packs four 24-bit pixels into three
// 32-bit words, and generates the Vsync/Hsync/frame_start strobes used by the
// SC read side. Also flags FIFO overflow and frames cut short by an early
// start-of-frame.
module mipi_sc_line_writer #(
    parameter int H_ACTIVE       = 1080,
    parameter int V_ACTIVE       = 2160,
    parameter int WORDS_PER_LINE = H_ACTIVE * 3 / 4
) (
    input  logic        CLK_tx,
    input  logic        RSTn,
    input  logic        pix_sof,
    input  logic        pix_valid,
    input  logic [23:0] pix_data,
    output logic        pix_ready,
    input  logic        fifo_almostfull,
    input  logic        fifo_full,
    output logic        fifo_wren,
    output logic [31:0] fifo_wdata,
    output logic        Vsync,
    output logic        Hsync,
    output logic        frame_start,
    output logic [11:0] line_cnt,
    output logic        err_overflow,
    output logic        err_short_frame
);

    // Word counter width; the line ends on the write that brings it to WORDS_PER_LINE.
    localparam int WCW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_LINE_END = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t          state_r;
    logic [1:0]      phase_r;
    logic [23:0]     residue_r;
    logic [WCW-1:0]  word_cnt_r;

    logic            accept_s;
    logic            last_pix_s;
    logic [31:0]     word_s;
    logic [23:0]     residue_nxt_s;
    logic [11:0]     line_cnt_inc_s;

    // The SOF term keeps a pixel from being taken in the cycle a new frame restarts.
    assign pix_ready = (state_r == ST_ACTIVE) && !fifo_almostfull && !pix_sof;
    assign accept_s  = pix_valid && pix_ready;

    // The last pixel of a line is the phase-3 pixel that completes the final word.
    assign last_pix_s = (phase_r == 2'd3) && (word_cnt_r == WCW'(WORDS_PER_LINE - 1));

    // Next line count, held at V_ACTIVE once the frame is complete.
    always_comb begin
        line_cnt_inc_s = line_cnt;
        if (line_cnt < 12'(V_ACTIVE)) begin
            line_cnt_inc_s = line_cnt + 12'd1;
        end else begin
            line_cnt_inc_s = line_cnt;
        end
    end

    // Pack the accepted pixel with the leftover bits of the previous pixel.
    always_comb begin
        word_s        = 32'd0;
        residue_nxt_s = 24'd0;
        case (phase_r)
            2'd0: begin
                word_s        = 32'd0;
                residue_nxt_s = pix_data;
            end
            2'd1: begin
                word_s        = {pix_data[7:0], residue_r};
                residue_nxt_s = {8'd0, pix_data[23:8]};
            end
            2'd2: begin
                word_s        = {pix_data[15:0], residue_r[15:0]};
                residue_nxt_s = {16'd0, pix_data[23:16]};
            end
            2'd3: begin
                word_s        = {pix_data, residue_r[7:0]};
                residue_nxt_s = 24'd0;
            end
            default: begin
                word_s        = 32'd0;
                residue_nxt_s = 24'd0;
            end
        endcase
    end

    // Line/frame state machine with registered strobes, FIFO writes and error flags.
    always_ff @(posedge CLK_tx or negedge RSTn) begin
        if (!RSTn) begin
            state_r         <= ST_IDLE;
            phase_r         <= 2'd0;
            residue_r       <= 24'd0;
            word_cnt_r      <= '0;
            fifo_wren       <= 1'b0;
            fifo_wdata      <= 32'd0;
            Vsync           <= 1'b0;
            Hsync           <= 1'b0;
            frame_start     <= 1'b0;
            line_cnt        <= 12'd0;
            err_overflow    <= 1'b0;
            err_short_frame <= 1'b0;
        end else begin
            fifo_wren    <= 1'b0;
            Vsync        <= 1'b0;
            Hsync        <= 1'b0;
            // The write that hit a full FIFO has already gone out; only record it.
            err_overflow <= err_overflow | (fifo_wren & fifo_full);

            if (pix_sof) begin
                Vsync       <= 1'b1;
                frame_start <= 1'b0;
                line_cnt    <= 12'd0;
                phase_r     <= 2'd0;
                residue_r   <= 24'd0;
                word_cnt_r  <= '0;
                state_r     <= ST_ACTIVE;
                if ((state_r == ST_ACTIVE) || (state_r == ST_LINE_END)) begin
                    err_short_frame <= 1'b1;
                end else begin
                    err_short_frame <= err_short_frame;
                end
            end else begin
                if (Vsync) begin
                    frame_start <= 1'b1;
                end else begin
                    frame_start <= frame_start;
                end

                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_ACTIVE: begin
                        if (accept_s) begin
                            phase_r   <= phase_r + 2'd1;
                            residue_r <= residue_nxt_s;
                            if (phase_r != 2'd0) begin
                                fifo_wren  <= 1'b1;
                                fifo_wdata <= word_s;
                            end else begin
                                fifo_wren  <= 1'b0;
                            end
                            if (last_pix_s) begin
                                word_cnt_r <= '0;
                                state_r    <= ST_LINE_END;
                            end else if (phase_r != 2'd0) begin
                                word_cnt_r <= word_cnt_r + WCW'(1);
                            end else begin
                                word_cnt_r <= word_cnt_r;
                            end
                        end else begin
                            state_r <= ST_ACTIVE;
                        end
                    end
                    ST_LINE_END: begin
                        // Final word went out last cycle; announce the line now.
                        Hsync    <= 1'b1;
                        line_cnt <= line_cnt_inc_s;
                        if (line_cnt_inc_s >= 12'(V_ACTIVE)) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_ACTIVE;
                        end
                    end
                    ST_DONE: begin
                        state_r <= ST_DONE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mipi_sc_line_writer.sv
// tb_mipi_sc_line_writer
// Directed bench: one full-size instance (1080x2160) and one small instance
// (8x4) driven from shared stimulus; writes and Hsyncs are collected by a
// negedge monitor and compared against hand-computed values.
module tb_mipi_sc_line_writer;

    logic        clk;
    logic        rstn;
    logic        sof;
    logic        valid;
    logic [23:0] data;
    logic        afull;
    logic        full;

    logic        l_ready, l_wren, l_vs, l_hs, l_fs, l_eo, l_es;
    logic [31:0] l_wdata;
    logic [11:0] l_lc;
    logic        s_ready, s_wren, s_vs, s_hs, s_fs, s_eo, s_es;
    logic [31:0] s_wdata;
    logic [11:0] s_lc;

    int checks = 0;
    int errors = 0;

    // Monitor state
    logic        mon_clr = 1'b0;
    int          cyc = 0;
    int          l_w = 0, l_h = 0, s_w = 0, s_h = 0;
    int          l_last_w_cyc = 0, l_h_cyc = 0;
    logic [31:0] lq[$];
    logic [31:0] sq[$];

    mipi_sc_line_writer dut_l (
        .CLK_tx(clk), .RSTn(rstn), .pix_sof(sof), .pix_valid(valid), .pix_data(data),
        .pix_ready(l_ready), .fifo_almostfull(afull), .fifo_full(full),
        .fifo_wren(l_wren), .fifo_wdata(l_wdata), .Vsync(l_vs), .Hsync(l_hs),
        .frame_start(l_fs), .line_cnt(l_lc), .err_overflow(l_eo), .err_short_frame(l_es)
    );

    mipi_sc_line_writer #(.H_ACTIVE(8), .V_ACTIVE(4), .WORDS_PER_LINE(6)) dut_s (
        .CLK_tx(clk), .RSTn(rstn), .pix_sof(sof), .pix_valid(valid), .pix_data(data),
        .pix_ready(s_ready), .fifo_almostfull(afull), .fifo_full(full),
        .fifo_wren(s_wren), .fifo_wdata(s_wdata), .Vsync(s_vs), .Hsync(s_hs),
        .frame_start(s_fs), .line_cnt(s_lc), .err_overflow(s_eo), .err_short_frame(s_es)
    );

    // 100 MHz transmit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Collect writes and Hsyncs away from the active edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mon_clr) begin
            l_w <= 0; l_h <= 0; s_w <= 0; s_h <= 0;
            lq.delete();
            sq.delete();
        end else begin
            if (l_wren) begin
                l_w <= l_w + 1;
                l_last_w_cyc <= cyc;
                lq.push_back(l_wdata);
            end
            if (l_hs) begin
                l_h <= l_h + 1;
                l_h_cyc <= cyc;
            end
            if (s_wren) begin
                s_w <= s_w + 1;
                sq.push_back(s_wdata);
            end
            if (s_hs) s_h <= s_h + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; sof = 1'b0; valid = 1'b0; data = 24'd0; afull = 1'b0; full = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        tick();
    endtask

    task automatic pulse_sof();
        sof = 1'b1;
        tick();
        sof = 1'b0;
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
        tick();
    endtask

    // Present one pixel and hold it until the selected instance takes it.
    task automatic push(input logic [23:0] d, input bit use_small);
        int n;
        n = 0;
        valid = 1'b1;
        data  = d;
        #1;
        while (!(use_small ? s_ready : l_ready) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) check_val("ready_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    function automatic logic [23:0] pix(input int i);
        logic [31:0] v;
        v = 32'(i) * 32'd40503 + 32'd12345;
        return v[23:0];
    endfunction

    // Expected k-th word of a line built from pix(0), pix(1), ...
    function automatic logic [31:0] exp_word(input int k);
        logic [23:0] p0, p1, p2, p3;
        int g;
        g  = k / 3;
        p0 = pix(4 * g);     p1 = pix(4 * g + 1);
        p2 = pix(4 * g + 2); p3 = pix(4 * g + 3);
        case (k % 3)
            0:       return {p1[7:0], p0};
            1:       return {p2[15:0], p1[23:8]};
            default: return {p3, p2[23:16]};
        endcase
    endfunction

    task automatic push_pack_set(input bit use_small);
        push(24'h112233, use_small);
        push(24'h445566, use_small);
        push(24'h778899, use_small);
        push(24'hAABBCC, use_small);
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int w0, rdy_hi, bad;

        // Reset state
        rstn = 1'b0; sof = 1'b0; valid = 1'b0; data = 24'd0; afull = 1'b0; full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_wren",  {31'd0, l_wren}, 32'd0);
        check_val("rst_wdata", l_wdata, 32'd0);
        check_val("rst_strobes", {28'd0, l_vs, l_hs, l_fs, l_ready}, 32'd0);
        check_val("rst_lc",    {20'd0, l_lc}, 32'd0);
        check_val("rst_errs",  {30'd0, l_eo, l_es}, 32'd0);
        rstn = 1'b1;
        tick();

        // Packing of four pixels into three words
        pulse_sof();
        check_val("sof_vsync", {31'd0, l_vs}, 32'd1);
        check_val("sof_fs_low", {31'd0, l_fs}, 32'd0);
        clr_mon();
        check_val("fs_set", {30'd0, l_fs, l_vs}, 32'd2);
        push_pack_set(1'b0);
        check_val("pack_cnt", 32'(lq.size()), 32'd3);
        check_val("pack_w0", lq[0], 32'h66112233);
        check_val("pack_w1", lq[1], 32'h88994455);
        check_val("pack_w2", lq[2], 32'hAABBCC77);
        check_val("sof_idle_no_err", {31'd0, l_es}, 32'd0);

        // Full 1080-pixel line with a 20-cycle back-pressure window mid-line
        do_reset();
        pulse_sof();
        clr_mon();
        for (int i = 0; i < 540; i++) push(pix(i), 1'b0);
        afull = 1'b1;
        tick();
        w0 = l_w;
        check_val("bp_words_before", 32'(w0), 32'd405);
        rdy_hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (l_ready) rdy_hi++;
            tick();
        end
        check_val("bp_ready_low", 32'(rdy_hi), 32'd0);
        check_val("bp_no_writes", 32'(l_w), 32'(w0));
        afull = 1'b0;
        for (int i = 540; i < 1080; i++) push(pix(i), 1'b0);
        repeat (3) tick();
        check_val("line_writes", 32'(l_w), 32'd810);
        check_val("line_hsync", 32'(l_h), 32'd1);
        check_val("line_cnt1", {20'd0, l_lc}, 32'd1);
        check_val("hsync_after_last_wr", 32'(l_h_cyc - l_last_w_cyc), 32'd1);
        bad = 0;
        for (int k = 0; k < 810; k++) begin
            if (k >= lq.size() || lq[k] !== exp_word(k)) bad++;
        end
        check_val("line_word_errs", 32'(bad), 32'd0);
        check_val("ready_next_line", {31'd0, l_ready}, 32'd1);

        // Small frame: 4 lines of 8 pixels
        do_reset();
        pulse_sof();
        clr_mon();
        for (int i = 0; i < 32; i++) push(pix(i), 1'b1);
        repeat (3) tick();
        check_val("frm_hsyncs", 32'(s_h), 32'd4);
        check_val("frm_writes", 32'(s_w), 32'd24);
        check_val("frm_lc", {20'd0, s_lc}, 32'd4);
        check_val("frm_done_ready", {31'd0, s_ready}, 32'd0);
        check_val("frm_fs_high", {31'd0, s_fs}, 32'd1);
        pulse_sof();
        check_val("frm2_vs_fs", {30'd0, s_vs, s_fs}, 32'd2);
        check_val("frm2_lc", {20'd0, s_lc}, 32'd0);
        check_val("frm2_no_short", {31'd0, s_es}, 32'd0);
        tick();
        check_val("frm2_fs_back", {30'd0, s_vs, s_fs}, 32'd1);

        // Early SOF after two of four lines, two pixels into the third
        for (int i = 0; i < 16; i++) push(pix(i), 1'b1);
        repeat (3) tick();
        check_val("early_lc2", {20'd0, s_lc}, 32'd2);
        push(pix(100), 1'b1);
        push(pix(101), 1'b1);
        pulse_sof();
        check_val("early_short", {31'd0, s_es}, 32'd1);
        check_val("early_vs", {31'd0, s_vs}, 32'd1);
        check_val("early_lc0", {20'd0, s_lc}, 32'd0);
        clr_mon();
        push_pack_set(1'b1);
        check_val("early_pack_cnt", 32'(sq.size()), 32'd3);
        check_val("early_pack_w0", sq[0], 32'h66112233);
        check_val("early_pack_w2", sq[2], 32'hAABBCC77);

        // Overflow, then reset in the middle of a line
        do_reset();
        full = 1'b1;
        pulse_sof();
        push(pix(0), 1'b0);
        tick();
        check_val("ovf_none_yet", {31'd0, l_eo}, 32'd0);
        for (int i = 1; i < 10; i++) push(pix(i), 1'b0);
        tick();
        check_val("ovf_set", {31'd0, l_eo}, 32'd1);
        check_val("mid_lc1", {20'd0, s_lc}, 32'd1);
        check_val("mid_ovf_s", {31'd0, s_eo}, 32'd1);
        rstn = 1'b0;
        #1;
        check_val("mid_rst_lc", {20'd0, s_lc}, 32'd0);
        check_val("mid_rst_flags", {25'd0, s_wren, s_vs, s_hs, s_fs, s_eo, s_es, s_ready}, 32'd0);
        check_val("mid_rst_wdata", s_wdata, 32'd0);
        check_val("mid_rst_ovf_l", {31'd0, l_eo}, 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        full = 1'b0;
        tick();
        pulse_sof();
        clr_mon();
        push_pack_set(1'b0);
        check_val("post_rst_cnt", 32'(lq.size()), 32'd3);
        check_val("post_rst_w0", lq[0], 32'h66112233);
        check_val("post_rst_w1", lq[1], 32'h88994455);
        check_val("post_rst_no_ovf", {31'd0, l_eo}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
